// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : layer_compositor
// Description : Scans the per-pixel layer stack in priority order through the
//               palette stage and emits the first opaque enabled colour, or
//               the background colour when every layer is transparent or off.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int  NUMBER_OF_LAYERS = 32,
    parameter int  PALETTE_SIZE     = 32,
    localparam int LAYER_WIDTH      = $clog2(NUMBER_OF_LAYERS),
    localparam int PALETTE_WIDTH    = $clog2(PALETTE_SIZE)
) (
    input  logic                                  clk_n,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUMBER_OF_LAYERS*PALETTE_WIDTH-1:0] in_idx,
    input  logic [NUMBER_OF_LAYERS-1:0]           in_layer_en,
    input  logic [23:0]                           bg_color,
    output logic [LAYER_WIDTH-1:0]                pipe_layer,
    output logic [PALETTE_WIDTH-1:0]              pipe_palette_idx,
    input  logic [23:0]                           pal_data,
    input  logic                                  pal_pixel_valid,
    input  logic                                  pal_ctrl_busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [23:0]                           out_rgb,
    output logic                                  out_hit,
    output logic [LAYER_WIDTH-1:0]                out_layer
);

    localparam logic [LAYER_WIDTH-1:0] c_LAST_LAYER = LAYER_WIDTH'(NUMBER_OF_LAYERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                                        r_state;
    state_t                                        w_state_next;
    logic [LAYER_WIDTH-1:0]                        r_cnt;
    logic [LAYER_WIDTH-1:0]                        w_cnt_next;
    logic [NUMBER_OF_LAYERS-1:0][PALETTE_WIDTH-1:0] r_idx;
    logic [NUMBER_OF_LAYERS-1:0]                   r_en;
    logic [23:0]                                   r_rgb;
    logic                                          r_hit;
    logic [LAYER_WIDTH-1:0]                        r_layer;
    logic                                          w_accept;
    logic                                          w_take_hit;
    logic                                          w_take_miss;
    logic                                          w_en_cur;

    // The palette stage is addressed straight from the scan counter so the
    // looked-up colour arrives in the same cycle it is evaluated.
    assign pipe_layer       = r_cnt;
    assign pipe_palette_idx = r_idx[r_cnt];
    assign w_en_cur         = r_en[r_cnt];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_rgb   = r_rgb;
    assign out_hit   = r_hit;
    assign out_layer = r_layer;

    // Next-state and scan-counter decision; a busy palette port freezes the scan.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_take_hit   = 1'b0;
        w_take_miss  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!pal_ctrl_busy) begin
                    if (w_en_cur && pal_pixel_valid) begin
                        w_take_hit   = 1'b1;
                        w_state_next = S_OUT;
                    end else if (r_cnt == c_LAST_LAYER) begin
                        w_take_miss  = 1'b1;
                        w_state_next = S_OUT;
                    end else begin
                        w_cnt_next   = r_cnt + LAYER_WIDTH'(1);
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and scan counter registers.
    always_ff @(posedge clk_n) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Pixel capture on accept and result capture at the scan decision; the
    // result is held untouched through OUT until the handshake completes.
    always_ff @(posedge clk_n) begin
        if (!rst) begin
            r_idx   <= '0;
            r_en    <= '0;
            r_rgb   <= '0;
            r_hit   <= 1'b0;
            r_layer <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= in_idx;
                r_en  <= in_layer_en;
            end
            if (w_take_hit) begin
                r_rgb   <= pal_data;
                r_hit   <= 1'b1;
                r_layer <= r_cnt;
            end else if (w_take_miss) begin
                r_rgb   <= bg_color;
                r_hit   <= 1'b0;
                r_layer <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_compositor
// Description : Directed bench for layer_compositor with a priority-scan model,
//               a per-cycle output/address checker and literal result pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    localparam int N  = 32;
    localparam int PW = 5;
    localparam int LW = 5;

    logic            clk_n = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*PW-1:0] in_idx;
    logic [N-1:0]    in_layer_en;
    logic [23:0]     bg_color;
    logic [LW-1:0]   pipe_layer;
    logic [PW-1:0]   pipe_palette_idx;
    logic [23:0]     pal_data;
    logic            pal_pixel_valid;
    logic            pal_ctrl_busy;
    logic            out_valid;
    logic            out_ready;
    logic [23:0]     out_rgb;
    logic            out_hit;
    logic [LW-1:0]   out_layer;

    layer_compositor #(.NUMBER_OF_LAYERS(N), .PALETTE_SIZE(32)) dut (
        .clk_n(clk_n), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_layer_en(in_layer_en), .bg_color(bg_color),
        .pipe_layer(pipe_layer), .pipe_palette_idx(pipe_palette_idx),
        .pal_data(pal_data), .pal_pixel_valid(pal_pixel_valid), .pal_ctrl_busy(pal_ctrl_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rgb(out_rgb), .out_hit(out_hit), .out_layer(out_layer)
    );

    always #5 clk_n = ~clk_n;

    int cyc = 0;
    always @(posedge clk_n) cyc <= cyc + 1;

    // Palette stage stand-in: combinational lookup, garbage while busy.
    logic [23:0] pal [N][32];
    assign pal_data        = pal_ctrl_busy ? 24'hDEAD01 : pal[pipe_layer][pipe_palette_idx];
    assign pal_pixel_valid = pal_ctrl_busy | (pal[pipe_layer][pipe_palette_idx] != 24'h0);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Expectation for the pixel in flight (written by the driver only).
    int          issued = 0;
    int          exp_T, exp_tv, exp_s, exp_len;
    logic [23:0] exp_rgb;
    logic        exp_hit;
    logic [4:0]  exp_layer;
    logic [N*PW-1:0] exp_idx;

    // Results of the compare process (written by it only).
    int          completed = 0;
    logic        post_hs = 1'b0;
    logic        seen_valid = 1'b0;
    int          cap_lat = 0;
    logic [23:0] cap_rgb = '0;
    logic        cap_hit = 1'b0;
    logic [4:0]  cap_layer = '0;

    // Model: first enabled layer with a non-zero palette colour wins.
    task automatic model(input logic [N*PW-1:0] idx, input logic [N-1:0] en, input logic [23:0] bg,
                         output logic h, output logic [4:0] ly, output logic [23:0] rgb, output int k);
        h = 1'b0; ly = '0; rgb = bg; k = N - 1;
        for (int l = N - 1; l >= 0; l--) begin
            if (en[l] && pal[l][idx[l*PW +: PW]] != 24'h0) begin
                h = 1'b1; ly = 5'(l); rgb = pal[l][idx[l*PW +: PW]]; k = l;
            end
        end
    endtask

    // Per-cycle compare of handshake, scan addresses and held results.
    int r_rel, r_st, r_c;
    always @(negedge clk_n) begin
        if (rst) begin
            if (post_hs) begin
                chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
                chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
                post_hs <= 1'b0;
            end
            if (issued != completed) begin
                if (cyc > exp_T) chk("in_ready_while_busy", {63'd0, in_ready}, 64'd0);
                if (cyc < exp_tv) begin
                    chk("early_out_valid", {63'd0, out_valid}, 64'd0);
                    if (cyc > exp_T) begin
                        r_rel = cyc - exp_T - 1;
                        r_st  = r_rel - exp_s;
                        if (r_st < 0) r_st = 0;
                        if (r_st > exp_len) r_st = exp_len;
                        r_c = r_rel - r_st;
                        chk("pipe_layer", 64'(pipe_layer), 64'(r_c));
                        chk("pipe_palette_idx", 64'(pipe_palette_idx), 64'(exp_idx[r_c*PW +: PW]));
                    end
                end else begin
                    chk("out_valid", {63'd0, out_valid}, 64'd1);
                    chk("out_rgb", 64'(out_rgb), 64'(exp_rgb));
                    chk("out_hit", {63'd0, out_hit}, {63'd0, exp_hit});
                    chk("out_layer", 64'(out_layer), 64'(exp_layer));
                    if (out_valid && !seen_valid) begin
                        cap_lat    <= cyc - exp_T;
                        seen_valid <= 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        cap_rgb    <= out_rgb;
                        cap_hit    <= out_hit;
                        cap_layer  <= out_layer;
                        completed  <= completed + 1;
                        post_hs    <= 1'b1;
                        seen_valid <= 1'b0;
                    end else if (cyc > exp_tv + 60) begin
                        completed  <= completed + 1;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk_n); #1; guard++; end
    endtask

    // Offer one pixel, drive busy window [s, s+len) of scan cycles and an
    // out_ready delay, optionally pushing a rejected pixel during OUT.
    task automatic send(input logic [N*PW-1:0] idx, input logic [N-1:0] en, input logic [23:0] bg,
                        input int s, input int len, input int rdelay, input bit hold);
        int guard; int k; int rr; logic h; logic [4:0] ly; logic [23:0] rgb;
        wait_ready();
        model(idx, en, bg, h, ly, rgb, k);
        exp_T = cyc; exp_tv = cyc + 2 + k + ((s <= k) ? len : 0);
        exp_s = s; exp_len = len; exp_rgb = rgb; exp_hit = h; exp_layer = ly; exp_idx = idx;
        in_idx = idx; in_layer_en = en; bg_color = bg; in_valid = 1'b1;
        issued++;
        guard = 0;
        do begin
            @(posedge clk_n); #1; guard++;
            rr = cyc - exp_T - 1;
            pal_ctrl_busy = (rr >= s) && (rr < s + len);
            out_ready     = (rdelay == 0) || (cyc >= exp_tv + rdelay);
            in_valid      = hold && (cyc >= exp_tv);
            if (in_valid) begin in_idx = ~idx; in_layer_en = '1; end
        end while (completed != issued && guard < 200);
        pal_ctrl_busy = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (guard >= 200) chk("driver_timeout", 64'(completed), 64'(issued));
    endtask

    task automatic clear_pal();
        for (int l = 0; l < N; l++) for (int e = 0; e < 32; e++) pal[l][e] = 24'h0;
    endtask

    logic [N*PW-1:0] iv;
    int              t_acc;
    int              vcount;
    logic [N-1:0]    ren;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_idx = '0; in_layer_en = '0; bg_color = '0;
        pal_ctrl_busy = 1'b0; out_ready = 1'b1;
        clear_pal();
        repeat (3) @(posedge clk_n);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_rgb", 64'(out_rgb), 64'd0);
        chk("rst_out_hit", {63'd0, out_hit}, 64'd0);
        chk("rst_out_layer", 64'(out_layer), 64'd0);
        rst = 1'b1;
        @(posedge clk_n); #1;

        // Single-layer hit on layer 0.
        clear_pal(); pal[0][3] = 24'h123456;
        iv = '0; iv[0 +: PW] = 5'd3;
        send(iv, 32'h1, 24'h0, 99, 0, 0, 1'b0);
        chk("t1_lat", 64'(cap_lat), 64'd2);
        chk("t1_rgb", 64'(cap_rgb), 64'h123456);
        chk("t1_hit", {63'd0, cap_hit}, 64'd1);
        chk("t1_layer", 64'(cap_layer), 64'd0);

        // Layers 0-4 transparent, layer 5 wins over a later opaque layer 6.
        clear_pal(); pal[5][7] = 24'hFF0000; pal[6][0] = 24'h111111;
        iv = '0;
        for (int l = 0; l < 5; l++) iv[l*PW +: PW] = 5'd1;
        iv[5*PW +: PW] = 5'd7;
        send(iv, '1, 24'h0, 99, 0, 0, 1'b0);
        chk("t2_lat", 64'(cap_lat), 64'd7);
        chk("t2_rgb", 64'(cap_rgb), 64'hFF0000);
        chk("t2_layer", 64'(cap_layer), 64'd5);

        // Everything disabled: background after a full scan.
        send(iv, '0, 24'h0000AA, 99, 0, 0, 1'b0);
        chk("t3_lat", 64'(cap_lat), 64'd33);
        chk("t3_rgb", 64'(cap_rgb), 64'h0000AA);
        chk("t3_hit", {63'd0, cap_hit}, 64'd0);
        chk("t3_layer", 64'(cap_layer), 64'd0);

        // Disabled opaque layer 2 skipped, layer 9 wins, 3-cycle busy stall.
        clear_pal(); pal[2][4] = 24'h00FF00; pal[9][6] = 24'h0000FF; pal[12][1] = 24'hABCDEF;
        iv = '0; iv[2*PW +: PW] = 5'd4; iv[9*PW +: PW] = 5'd6; iv[12*PW +: PW] = 5'd1;
        send(iv, ~(32'h1 << 2), 24'h0, 4, 3, 0, 1'b0);
        chk("t4_lat", 64'(cap_lat), 64'd14);
        chk("t4_rgb", 64'(cap_rgb), 64'h0000FF);
        chk("t4_layer", 64'(cap_layer), 64'd9);

        // Backpressure for 5 cycles with a competing pixel offered during OUT.
        clear_pal(); pal[1][2] = 24'h445566;
        iv = '0; iv[1*PW +: PW] = 5'd2;
        send(iv, '1, 24'h0, 99, 0, 5, 1'b1);
        chk("t5_lat", 64'(cap_lat), 64'd3);
        chk("t5_rgb", 64'(cap_rgb), 64'h445566);
        chk("t5_layer", 64'(cap_layer), 64'd1);
        // Accepted in the first idle cycle after the handshake.
        pal[0][0] = 24'h010203;
        send('0, 32'h1, 24'h0, 99, 0, 0, 1'b0);
        chk("t5b_rgb", 64'(cap_rgb), 64'h010203);
        chk("t5b_lat", 64'(cap_lat), 64'd2);

        // Assorted pixels with random palettes, masks, stalls and backpressure.
        for (int it = 0; it < 6; it++) begin
            clear_pal();
            for (int l = 0; l < N; l++) begin
                iv[l*PW +: PW] = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) pal[l][iv[l*PW +: PW]] = 24'($urandom) | 24'h1;
            end
            ren = 32'($urandom);
            send(iv, ren, 24'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset mid-scan at cnt = 10 discards the pixel.
        clear_pal(); pal[20][2] = 24'h777777;
        for (int l = 0; l < N; l++) iv[l*PW +: PW] = 5'd2;
        wait_ready();
        in_idx = iv; in_layer_en = '1; in_valid = 1'b1; t_acc = cyc;
        @(posedge clk_n); #1; in_valid = 1'b0;
        while (cyc < t_acc + 11) begin @(posedge clk_n); #1; end
        chk("t6_pipe_layer_pre", 64'(pipe_layer), 64'd10);
        rst = 1'b0;
        @(posedge clk_n); #1;
        rst = 1'b1;
        chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_out_rgb", 64'(out_rgb), 64'd0);
        chk("t6_out_hit", {63'd0, out_hit}, 64'd0);
        chk("t6_out_layer", 64'(out_layer), 64'd0);
        chk("t6_pipe_layer", 64'(pipe_layer), 64'd0);
        vcount = 0;
        repeat (40) begin @(negedge clk_n); if (out_valid) vcount++; end
        chk("t6_no_out_pulse", 64'(vcount), 64'd0);

        // Normal operation after the mid-scan reset.
        @(posedge clk_n); #1;
        pal[3][2] = 24'h0A0B0C;
        send(iv, '1, 24'h0, 1, 2, 1, 1'b0);
        chk("t7_rgb", 64'(cap_rgb), 64'h0A0B0C);
        chk("t7_layer", 64'(cap_layer), 64'd3);
        chk("t7_lat", 64'(cap_lat), 64'd7);

        repeat (3) @(posedge clk_n);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
